// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by alu_seq_hs and alu_mul_iter
package alu_pkg;
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_PASSB = 3'b100;
    localparam logic [2:0] OP_SLT   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add unsigned multiplier, one partial product per cycle
// Ports: clk, rst_n (async active-low); i_start latches i_a/i_b and restarts;
//        o_busy while iterating or presenting; o_done for one cycle with o_product valid.
module alu_mul_iter #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    // Done is raised once all WIDTH iterations are in the accumulator, so the
    // consumer registers the product one cycle after the last iteration.
    assign o_done    = r_busy && (r_cnt == CW'(WIDTH));
    assign o_busy    = r_busy;
    assign o_product = r_acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= {{WIDTH{1'b0}}, i_b};
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (o_done) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            if (r_mcand[0]) r_acc <= r_acc + r_mplier;
            r_mcand  <= r_mcand >> 1;
            r_mplier <= r_mplier << 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/alu_seq_hs.sv
// alu_seq_hs: handshaked ALU with registered result and N/Z/C/V/err flags plus an iterative MUL
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, op (operand side);
//        out_valid/out_ready with c, zero, neg, carry, ovf, err (result side).
module alu_seq_hs
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             err
);
    state_e             r_state;
    logic [WIDTH-1:0]   r_c;
    logic               r_out_valid, r_zero, r_neg, r_carry, r_ovf, r_err;
    logic               w_accept, w_is_mul, w_load, w_mul_busy, w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_sum, w_diff;
    logic [WIDTH-1:0]   w_alu_c, w_res;
    logic               w_alu_carry, w_alu_ovf, w_alu_err;
    logic               w_res_carry, w_res_ovf, w_res_err;
    assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_is_mul = MUL_EN && (op == OP_MUL);
    assign w_sum    = {1'b0, a} + {1'b0, b};
    // Bit WIDTH of the difference is the borrow, so carry is its inverse.
    assign w_diff   = {1'b0, a} - {1'b0, b};
    always_comb begin
        w_alu_c     = '0;
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        w_alu_err   = 1'b0;
        case (op)
            OP_ADD: begin
                w_alu_c     = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
                w_alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_c     = w_diff[WIDTH-1:0];
                w_alu_carry = !w_diff[WIDTH];
                w_alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   w_alu_c = a & b;
            OP_OR:    w_alu_c = a | b;
            OP_PASSB: w_alu_c = b;
            OP_SLT:   w_alu_c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_MUL:   w_alu_err = !MUL_EN;
            default:  w_alu_err = 1'b1;
        endcase
    end
    // In ST_MUL the only register load is the finished product.
    assign w_res       = (r_state == ST_MUL) ? w_prod[WIDTH-1:0] : w_alu_c;
    assign w_res_carry = (r_state == ST_MUL) ? |w_prod[2*WIDTH-1:WIDTH] : w_alu_carry;
    assign w_res_ovf   = (r_state == ST_MUL) ? 1'b0 : w_alu_ovf;
    assign w_res_err   = (r_state == ST_MUL) ? 1'b0 : w_alu_err;
    assign w_load      = ((r_state == ST_IDLE) && w_accept && !w_is_mul) ||
                         ((r_state == ST_MUL) && w_mul_done);
    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_start   (w_accept && w_is_mul),
                .i_a       (a),
                .i_b       (b),
                .o_busy    (w_mul_busy),
                .o_done    (w_mul_done),
                .o_product (w_prod)
            );
        end else begin : g_nomul
            assign w_mul_busy = 1'b0;
            assign w_mul_done = 1'b0;
            assign w_prod     = '0;
        end
    endgenerate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_load) begin
                r_c     <= w_res;
                r_zero  <= (w_res == '0);
                r_neg   <= w_res[WIDTH-1];
                r_carry <= w_res_carry;
                r_ovf   <= w_res_ovf;
                r_err   <= w_res_err;
            end
            case (r_state)
                ST_IDLE: begin
                    // Any accept implies the old result is gone; a MUL accept leaves nothing valid.
                    if (w_accept) r_out_valid <= !w_is_mul;
                    else if (out_ready) r_out_valid <= 1'b0;
                    if (w_accept && w_is_mul) r_state <= ST_MUL;
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else if (!w_mul_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign err       = r_err;
endmodule
